axi4_lite_regs: RTL and testbench

AXI4-Lite slave-side register bank: the responder that sits on the `slave` end of `axi4_lite_if` and terminates master transactions. It holds `N_RW` read/write control registers, which drive fabric logic through a flat output vector. It also exposes `N_RO` read-only status registers, sampled from fabric inputs. It is the standard CSR endpoint behind an AXI4-Lite interconnect port.

---
 rtl/axi4_lite_regs.sv | 182 ++++++++++++++++++
 tb/tb_axi4_lite_regs.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_regs.sv
// AXI4-Lite CSR endpoint: N_RW read/write control words driven out on ctrl_o,
// plus N_RO read-only status words sampled from status_i.
module axi4_lite_regs #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int N_RW   = 8,
    parameter int N_RO   = 8
) (
    input  logic                   ACLK,
    input  logic                   ARESETn,

    input  logic                   AWVALID,
    output logic                   AWREADY,
    input  logic [ADDR_W-1:0]      AWADDR,
    input  logic [2:0]             AWPROT,

    input  logic                   WVALID,
    output logic                   WREADY,
    input  logic [DATA_W-1:0]      WDATA,
    input  logic                   WSTRB,

    output logic                   BVALID,
    input  logic                   BREADY,
    output logic                   BRESP,

    input  logic                   ARVALID,
    output logic                   ARREADY,
    input  logic [ADDR_W-1:0]      ARADDR,
    input  logic [2:0]             ARPROT,

    output logic                   RVALID,
    input  logic                   RREADY,
    output logic [DATA_W-1:0]      RDATA,
    output logic                   RRESP,

    output logic [N_RW*DATA_W-1:0] ctrl_o,
    input  logic [N_RO*DATA_W-1:0] status_i
);

    localparam int OFFS  = $clog2(DATA_W / 8);
    localparam int IDX_W = ADDR_W - OFFS;

    typedef logic [IDX_W-1:0] idx_t;

    logic              aw_full_q, aw_full_d;
    idx_t              aw_idx_q, aw_idx_d;
    logic              w_full_q, w_full_d;
    logic [DATA_W-1:0] w_data_q, w_data_d;
    logic              w_strb_q, w_strb_d;
    logic              bvalid_q, bvalid_d;
    logic              bresp_q, bresp_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rresp_q, rresp_d;
    logic [DATA_W-1:0] ctrl_q [N_RW];
    logic [DATA_W-1:0] ctrl_d [N_RW];

    logic aw_hs, w_hs, ar_hs, commit;
    idx_t ar_idx;

    // Protection bits and byte-offset address bits carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{AWPROT, ARPROT, AWADDR, ARADDR};

    // READYs are forced low while reset is asserted.
    assign AWREADY = ARESETn && !aw_full_q && !bvalid_q;
    assign WREADY  = ARESETn && !w_full_q && !bvalid_q;
    assign ARREADY = ARESETn && !rvalid_q;

    assign aw_hs  = AWVALID && AWREADY;
    assign w_hs   = WVALID && WREADY;
    assign ar_hs  = ARVALID && ARREADY;
    assign commit = aw_full_q && w_full_q && !bvalid_q;
    assign ar_idx = ARADDR[ADDR_W-1:OFFS];

    assign BVALID = bvalid_q;
    assign BRESP  = bresp_q;
    assign RVALID = rvalid_q;
    assign RDATA  = rdata_q;
    assign RRESP  = rresp_q;

    for (genvar g = 0; g < N_RW; g++) begin : g_ctrl
        assign ctrl_o[g*DATA_W +: DATA_W] = ctrl_q[g];
    end

    always_comb begin
        aw_full_d = aw_full_q;
        aw_idx_d  = aw_idx_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        ctrl_d    = ctrl_q;

        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_idx_d  = AWADDR[ADDR_W-1:OFFS];
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            w_data_d = WDATA;
            w_strb_d = WSTRB;
        end

        // Anything not matching an RW index (RO or unmapped) is an error with no side effect.
        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = 1'b1;
            for (int i = 0; i < N_RW; i++) begin
                if (aw_idx_q == idx_t'(i)) begin
                    bresp_d = 1'b0;
                    if (w_strb_q) begin
                        ctrl_d[i] = w_data_q;
                    end
                end
            end
        end else if (bvalid_q && BREADY) begin
            bvalid_d = 1'b0;
        end
    end

    // Reads sample ctrl_q before this edge's commit, so a same-edge write is not yet visible.
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;

        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = '0;
            rresp_d  = 1'b1;
            for (int i = 0; i < N_RW; i++) begin
                if (ar_idx == idx_t'(i)) begin
                    rdata_d = ctrl_q[i];
                    rresp_d = 1'b0;
                end
            end
            for (int j = 0; j < N_RO; j++) begin
                if (ar_idx == idx_t'(N_RW + j)) begin
                    rdata_d = status_i[j*DATA_W +: DATA_W];
                    rresp_d = 1'b0;
                end
            end
        end else if (rvalid_q && RREADY) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            aw_full_q <= 1'b0;
            aw_idx_q  <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= 1'b0;
            for (int i = 0; i < N_RW; i++) begin
                ctrl_q[i] <= '0;
            end
        end else begin
            aw_full_q <= aw_full_d;
            aw_idx_q  <= aw_idx_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            ctrl_q    <= ctrl_d;
        end
    end

endmodule

// File: tb/tb_axi4_lite_regs.sv
// Directed plus randomized bench for axi4_lite_regs, checked against an
// array-based model of the register map.
module tb_axi4_lite_regs;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int N_RW   = 8;
    localparam int N_RO   = 8;
    localparam int N_ALL  = N_RW + N_RO;

    logic                   ACLK = 1'b0;
    logic                   ARESETn;
    logic                   AWVALID, AWREADY;
    logic [ADDR_W-1:0]      AWADDR;
    logic [2:0]             AWPROT;
    logic                   WVALID, WREADY;
    logic [DATA_W-1:0]      WDATA;
    logic                   WSTRB;
    logic                   BVALID, BREADY, BRESP;
    logic                   ARVALID, ARREADY;
    logic [ADDR_W-1:0]      ARADDR;
    logic [2:0]             ARPROT;
    logic                   RVALID, RREADY;
    logic [DATA_W-1:0]      RDATA;
    logic                   RRESP;
    logic [N_RW*DATA_W-1:0] ctrl_o;
    logic [N_RO*DATA_W-1:0] status_i;

    int total = 0;
    int bad   = 0;

    logic [31:0] modelRw [N_RW];

    axi4_lite_regs #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_RW(N_RW), .N_RO(N_RO)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
        .ctrl_o(ctrl_o), .status_i(status_i)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick;
        @(posedge ACLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic timeoutFail(input string tag);
        total++;
        bad++;
        $error("[TB] FAIL %s: observed=timeout expected=handshake", tag);
    endtask

    function automatic int idxOf(input logic [31:0] addr);
        return int'(addr >> 2);
    endfunction

    function automatic logic [31:0] ctrlWord(input int i);
        return ctrl_o[i*DATA_W +: DATA_W];
    endfunction

    function automatic void modelReset();
        for (int i = 0; i < N_RW; i++) modelRw[i] = '0;
    endfunction

    function automatic void modelWrite(input logic [31:0] addr, input logic [31:0] data,
                                       input logic strb, output logic resp);
        int idx = idxOf(addr);
        resp = (idx < N_RW) ? 1'b0 : 1'b1;
        if (idx < N_RW && strb) modelRw[idx] = data;
    endfunction

    function automatic void modelRead(input logic [31:0] addr, output logic [31:0] data,
                                      output logic resp);
        int idx = idxOf(addr);
        if (idx < N_RW) begin
            data = modelRw[idx];
            resp = 1'b0;
        end else if (idx < N_ALL) begin
            data = status_i[(idx-N_RW)*DATA_W +: DATA_W];
            resp = 1'b0;
        end else begin
            data = '0;
            resp = 1'b1;
        end
    endfunction

    task automatic checkCtrlAll(input string tag);
        for (int i = 0; i < N_RW; i++) checkOutput(tag, ctrlWord(i), modelRw[i]);
    endtask

    // W is raised first; AW follows wLead cycles later (0 = same cycle).
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                                 input logic strb, input int wLead);
        bit   awDone = 0, wDone = 0, awH, wH;
        int   n = 0;
        int   idx = idxOf(addr);
        logic expResp;
        AWADDR = addr;
        AWPROT = 3'($urandom);
        WDATA  = data;
        WSTRB  = strb;
        WVALID = 1'b1;
        while (!(awDone && wDone) && n < 50) begin
            if (n >= wLead && !awDone) AWVALID = 1'b1;
            awH = AWVALID && AWREADY;
            wH  = WVALID && WREADY;
            tick();
            n++;
            if (awH) begin AWVALID = 1'b0; awDone = 1; end
            if (wH)  begin WVALID  = 1'b0; wDone  = 1; end
        end
        if (!(awDone && wDone)) begin
            AWVALID = 1'b0;
            WVALID  = 1'b0;
            timeoutFail("wr_accept");
            return;
        end
        if (idx < N_RW) checkOutput("wr_ctrl_not_early", ctrlWord(idx), modelRw[idx]);
        checkOutput("wr_bvalid_k", BVALID, 1'b0);
        modelWrite(addr, data, strb, expResp);
        tick();
        checkOutput("wr_bvalid_k1", BVALID, 1'b1);
        checkOutput("wr_bresp", BRESP, expResp);
        checkCtrlAll("wr_ctrl");
        tick();
        checkOutput("wr_b_done", BVALID, 1'b0);
        checkOutput("wr_awready_after", AWREADY, 1'b1);
    endtask

    task automatic applyRead(input logic [31:0] addr);
        bit          arH = 0;
        int          n = 0;
        logic [31:0] expData;
        logic        expResp;
        ARADDR  = addr;
        ARPROT  = 3'($urandom);
        ARVALID = 1'b1;
        while (!arH && n < 50) begin
            arH = ARREADY;
            modelRead(addr, expData, expResp);
            tick();
            n++;
        end
        ARVALID = 1'b0;
        if (!arH) begin
            timeoutFail("rd_accept");
            return;
        end
        checkOutput("rd_rvalid", RVALID, 1'b1);
        checkOutput("rd_rdata", RDATA, expData);
        checkOutput("rd_rresp", RRESP, expResp);
        tick();
        checkOutput("rd_r_done", RVALID, 1'b0);
    endtask

    initial begin
        logic [31:0] addr, data, expData, held;
        logic        resp, expResp;

        ARESETn = 1'b0;
        AWVALID = 0; AWADDR = '0; AWPROT = '0;
        WVALID  = 0; WDATA  = '0; WSTRB  = 0;
        ARVALID = 0; ARADDR = '0; ARPROT = '0;
        BREADY  = 1'b1;
        RREADY  = 1'b1;
        for (int j = 0; j < N_RO; j++) status_i[j*DATA_W +: DATA_W] = $urandom;
        modelReset();

        // Reset values and READYs held low during reset.
        repeat (3) tick();
        checkOutput("rst_bvalid", BVALID, 1'b0);
        checkOutput("rst_rvalid", RVALID, 1'b0);
        checkOutput("rst_rdata", RDATA, 32'h0);
        checkOutput("rst_bresp", BRESP, 1'b0);
        checkOutput("rst_rresp", RRESP, 1'b0);
        checkOutput("rst_awready", AWREADY, 1'b0);
        checkOutput("rst_wready", WREADY, 1'b0);
        checkOutput("rst_arready", ARREADY, 1'b0);
        checkCtrlAll("rst_ctrl");
        ARESETn = 1'b1;
        #1;
        checkOutput("rel_awready", AWREADY, 1'b1);
        checkOutput("rel_wready", WREADY, 1'b1);
        checkOutput("rel_arready", ARREADY, 1'b1);
        tick();

        // Basic write/read, W-before-AW ordering, zero strobe, byte offset ignored.
        applyStimulus(32'h08, 32'hDEADBEEF, 1'b1, 0);
        checkOutput("wr_word2", ctrlWord(2), 32'hDEADBEEF);
        applyRead(32'h08);
        applyStimulus(32'h14, 32'hCAFE0001, 1'b1, 3);
        applyStimulus(32'h14, 32'h11111111, 1'b0, 1);
        checkOutput("strb0_word5", ctrlWord(5), 32'hCAFE0001);
        applyRead(32'h14);
        applyStimulus(32'h1B, 32'h0BADF00D, 1'b1, 0);
        applyRead(32'h18);

        // Error responses and status reads.
        applyStimulus(N_RW * 4, 32'hFFFF0000, 1'b1, 0);
        applyRead(N_RW * 4);
        applyRead(N_ALL * 4);
        status_i[3*DATA_W +: DATA_W] = 32'h12345678;
        applyRead((N_RW + 3) * 4);
        checkOutput("ro3_value", RDATA, 32'h12345678);
        applyStimulus(32'hFFFF_FFF0, 32'h13572468, 1'b1, 2);

        // B back-pressure with a second write stalled behind it.
        BREADY = 1'b0;
        AWADDR = 32'h0C; WDATA = 32'hA5A5A5A5; WSTRB = 1'b1;
        checkOutput("bp_awready_pre", AWREADY, 1'b1);
        AWVALID = 1'b1; WVALID = 1'b1;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        modelWrite(32'h0C, 32'hA5A5A5A5, 1'b1, resp);
        tick();
        checkOutput("bp_bvalid", BVALID, 1'b1);
        checkOutput("bp_word3", ctrlWord(3), 32'hA5A5A5A5);
        AWADDR = 32'h10; WDATA = 32'h5A5A5A5A; AWVALID = 1'b1; WVALID = 1'b1;
        for (int c = 0; c < 10; c++) begin
            checkOutput("bp_bvalid_hold", BVALID, 1'b1);
            checkOutput("bp_bresp_hold", BRESP, 1'b0);
            checkOutput("bp_awready_low", AWREADY, 1'b0);
            checkOutput("bp_wready_low", WREADY, 1'b0);
            checkOutput("bp_word4_stalled", ctrlWord(4), modelRw[4]);
            tick();
        end
        BREADY = 1'b1;
        tick();
        checkOutput("bp_b_done", BVALID, 1'b0);
        applyStimulus(32'h10, 32'h5A5A5A5A, 1'b1, 0);

        // R back-pressure: RDATA holds the value sampled at the AR edge.
        RREADY = 1'b0;
        held = 32'h600DCAFE;
        status_i[5*DATA_W +: DATA_W] = held;
        ARADDR = (N_RW + 5) * 4; ARVALID = 1'b1;
        tick();
        ARADDR = 32'h08;
        status_i[5*DATA_W +: DATA_W] = ~held;
        for (int c = 0; c < 10; c++) begin
            checkOutput("rbp_rvalid_hold", RVALID, 1'b1);
            checkOutput("rbp_rdata_hold", RDATA, held);
            checkOutput("rbp_rresp_hold", RRESP, 1'b0);
            checkOutput("rbp_arready_low", ARREADY, 1'b0);
            tick();
        end
        RREADY = 1'b1;
        tick();
        checkOutput("rbp_r_done", RVALID, 1'b0);
        applyRead(32'h08);

        // Same-edge commit and read of register 1.
        applyStimulus(32'h04, 32'h1, 1'b1, 0);
        AWADDR = 32'h04; WDATA = 32'h2; WSTRB = 1'b1; AWVALID = 1'b1; WVALID = 1'b1;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        ARADDR = 32'h04; ARVALID = 1'b1;
        checkOutput("same_arready", ARREADY, 1'b1);
        tick();
        ARVALID = 1'b0;
        modelWrite(32'h04, 32'h2, 1'b1, resp);
        checkOutput("same_rvalid", RVALID, 1'b1);
        checkOutput("same_rdata_old", RDATA, 32'h1);
        checkOutput("same_bvalid", BVALID, 1'b1);
        checkOutput("same_word1_new", ctrlWord(1), 32'h2);
        tick();
        applyRead(32'h04);

        // Randomized traffic against the model.
        for (int it = 0; it < 24; it++) begin
            addr = 32'($urandom_range(0, N_ALL + 1)) * 4 + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) addr = $urandom | 32'h8000_0000;
            data = $urandom;
            if ($urandom_range(0, 1) == 1)
                status_i[$urandom_range(0, N_RO-1)*DATA_W +: DATA_W] = $urandom;
            applyStimulus(addr, data, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
            applyRead(addr);
            applyRead(32'($urandom_range(0, N_ALL)) * 4);
        end

        // Reset while a B response is pending drops it for good.
        BREADY = 1'b0;
        AWADDR = 32'h18; WDATA = 32'h77777777; WSTRB = 1'b1; AWVALID = 1'b1; WVALID = 1'b1;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        tick();
        checkOutput("mid_bvalid_pre", BVALID, 1'b1);
        ARESETn = 1'b0;
        tick();
        modelReset();
        checkOutput("mid_bvalid_rst", BVALID, 1'b0);
        checkOutput("mid_awready_rst", AWREADY, 1'b0);
        checkCtrlAll("mid_ctrl_rst");
        ARESETn = 1'b1;
        BREADY = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            checkOutput("mid_no_bresp", BVALID, 1'b0);
            checkOutput("mid_no_rresp", RVALID, 1'b0);
        end
        applyRead(32'h18);
        modelRead(32'h18, expData, expResp);
        checkOutput("mid_word6_zero", expData | ctrlWord(6), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
